// File: rtl/vend_controller.sv
// Vending sequencer: accumulates coin credit, validates selections against
// price and stock, runs the dispense handshake, then pays change coin by coin.
module vend_controller #(
    parameter int unsigned                NPROD      = 4,
    parameter int unsigned                CREDIT_W   = 8,
    parameter int unsigned                CREDIT_MAX = 100,
    parameter logic [NPROD*CREDIT_W-1:0]  PRICES     = {8'd30, 8'd25, 8'd20, 8'd15},
    parameter int unsigned                STOCK_INIT = 3,
    parameter int unsigned                TIMEOUT    = 200
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          coin,
    input  logic                sel_valid,
    input  logic [1:0]          sel_id,
    input  logic                cancel,
    input  logic                restock,
    output logic                vend_valid,
    output logic [1:0]          vend_id,
    input  logic                vend_ready,
    output logic                chg_valid,
    output logic                chg_coin,
    input  logic                chg_ready,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic                sel_err,
    output logic [NPROD-1:0]    sold_out
);

    localparam int unsigned TIMER_W = $clog2(TIMEOUT + 1);
    localparam int unsigned SUM_W   = CREDIT_W + 1;
    localparam int unsigned STOCK_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } state_t;

    state_t               state_q, state_n;
    logic [CREDIT_W-1:0]  credit_n;
    logic [TIMER_W-1:0]   timer_q, timer_n;
    logic [STOCK_W-1:0]   stock_q [NPROD];

    logic [CREDIT_W-1:0]  coin_val;
    logic                 coin_ok;
    logic [SUM_W-1:0]     coin_sum;
    logic                 coin_fits;
    logic                 coin_take;

    logic [CREDIT_W-1:0]  price_sel;
    logic [STOCK_W-1:0]   stock_sel;
    logic                 id_ok;
    logic                 sel_ok;

    logic [1:0]           vend_id_n;
    logic                 vend_valid_n, chg_valid_n, chg_coin_n;
    logic                 coin_reject_n, sel_err_n;
    logic                 vend_fire, restock_fire;

    // Coin decode and overflow check against the registered credit
    always_comb begin
        coin_val = '0;
        coin_ok  = 1'b0;
        case (coin)
            2'b01: begin coin_val = CREDIT_W'(5);  coin_ok = 1'b1; end
            2'b10: begin coin_val = CREDIT_W'(10); coin_ok = 1'b1; end
            default: ;
        endcase
        coin_sum  = SUM_W'(credit) + SUM_W'(coin_val);
        coin_fits = coin_ok && (coin_sum <= SUM_W'(CREDIT_MAX));
    end

    // Price and stock of the selected product; out-of-range ids stay invalid
    always_comb begin
        price_sel = '0;
        stock_sel = '0;
        id_ok     = 1'b0;
        for (int unsigned i = 0; i < NPROD; i++) begin
            if (sel_id == 2'(i)) begin
                price_sel = PRICES[i*CREDIT_W +: CREDIT_W];
                stock_sel = stock_q[i];
                id_ok     = 1'b1;
            end
        end
        sel_ok = id_ok && (stock_sel != '0) && (credit >= price_sel);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_n;
            timer_q <= timer_n;
        end
    end

    always_comb begin
        state_n      = state_q;
        credit_n     = credit;
        timer_n      = '0;
        vend_id_n    = vend_id;
        sel_err_n    = 1'b0;
        coin_take    = 1'b0;
        vend_fire    = 1'b0;
        restock_fire = 1'b0;

        case (state_q)
            IDLE: begin
                restock_fire = restock;
                sel_err_n    = sel_valid;
                coin_take    = coin_fits;
                if (coin_fits) state_n = COLLECT;
            end
            COLLECT: begin
                if (cancel) begin
                    state_n = CHANGE;
                end else if (sel_valid && sel_ok) begin
                    state_n   = VEND;
                    credit_n  = credit - price_sel;
                    vend_id_n = sel_id;
                end else begin
                    sel_err_n = sel_valid;
                    coin_take = coin_fits;
                    // Quiet cycle: advance the inactivity timer or give up
                    if (!sel_valid && !coin_fits) begin
                        if (timer_q == TIMER_W'(TIMEOUT - 1)) state_n = CHANGE;
                        else                                  timer_n = timer_q + TIMER_W'(1);
                    end
                end
            end
            VEND: begin
                if (vend_ready) begin
                    vend_fire = 1'b1;
                    state_n   = (credit != '0) ? CHANGE : IDLE;
                end
            end
            CHANGE: begin
                if (chg_ready) begin
                    credit_n = credit - ((credit >= CREDIT_W'(10)) ? CREDIT_W'(10) : CREDIT_W'(5));
                    if (credit_n == '0) state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (coin_take) credit_n = CREDIT_W'(coin_sum);

        coin_reject_n = (coin != 2'b00) && !coin_take;
        vend_valid_n  = (state_n == VEND);
        chg_valid_n   = (state_n == CHANGE);
        chg_coin_n    = chg_valid_n && (credit_n >= CREDIT_W'(10));
    end

    // Registered outputs follow the next-state decision
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit      <= '0;
            vend_valid  <= 1'b0;
            vend_id     <= '0;
            chg_valid   <= 1'b0;
            chg_coin    <= 1'b0;
            coin_reject <= 1'b0;
            sel_err     <= 1'b0;
        end else begin
            credit      <= credit_n;
            vend_valid  <= vend_valid_n;
            vend_id     <= vend_id_n;
            chg_valid   <= chg_valid_n;
            chg_coin    <= chg_coin_n;
            coin_reject <= coin_reject_n;
            sel_err     <= sel_err_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NPROD; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
        end else if (restock_fire) begin
            for (int unsigned i = 0; i < NPROD; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
        end else if (vend_fire) begin
            for (int unsigned i = 0; i < NPROD; i++) begin
                if ((vend_id == 2'(i)) && (stock_q[i] != '0)) stock_q[i] <= stock_q[i] - STOCK_W'(1);
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NPROD; i++) sold_out[i] = (stock_q[i] == '0);
    end

endmodule

// File: tb/tb_vend_controller.sv
// Scenario bench for vend_controller: directed feature tests plus randomized
// transactions checked against a transaction-level credit/stock model.
module tb_vend_controller;

    logic       clk, rst;
    logic [1:0] coin;
    logic       sel_valid;
    logic [1:0] sel_id;
    logic       cancel, restock;
    logic       vend_valid;
    logic [1:0] vend_id;
    logic       vend_ready;
    logic       chg_valid, chg_coin, chg_ready;
    logic [7:0] credit;
    logic       coin_reject, sel_err;
    logic [3:0] sold_out;

    int    n_cmp = 0;
    int    n_bad = 0;
    int    stock_m [4];
    int    price_m [4] = '{15, 20, 25, 30};
    string got_str;
    bit    stable_ok;

    vend_controller dut (
        .clk(clk), .rst(rst), .coin(coin), .sel_valid(sel_valid), .sel_id(sel_id),
        .cancel(cancel), .restock(restock), .vend_valid(vend_valid), .vend_id(vend_id),
        .vend_ready(vend_ready), .chg_valid(chg_valid), .chg_coin(chg_coin),
        .chg_ready(chg_ready), .credit(credit), .coin_reject(coin_reject),
        .sel_err(sel_err), .sold_out(sold_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_coin(input logic [1:0] c);
        coin = c; tick(); coin = 2'b00;
    endtask

    task automatic pick(input logic [1:0] id);
        sel_valid = 1'b1; sel_id = id; tick(); sel_valid = 1'b0;
    endtask

    task automatic do_vend(input int hold);
        repeat (hold) tick();
        vend_ready = 1'b1; tick(); vend_ready = 1'b0;
    endtask

    task automatic pulse_cancel();
        cancel = 1'b1; tick(); cancel = 1'b0;
    endtask

    function automatic string change_plan(input int amt);
        string s;
        int    a;
        s = "";
        a = amt;
        while (a >= 10) begin s = {s, "10 "}; a -= 10; end
        if (a >= 5) s = {s, "5 "};
        return s;
    endfunction

    function automatic logic [3:0] sold_model();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (stock_m[i] == 0);
        return r;
    endfunction

    // Drains the change handshake with random stalls, recording coin values
    task automatic collect_change(input int max_stall);
        int   guard;
        int   st;
        logic held;
        got_str   = "";
        stable_ok = 1'b1;
        guard     = 0;
        while (chg_valid === 1'b1 && guard < 40) begin
            held = chg_coin;
            st   = $urandom_range(0, max_stall);
            chg_ready = 1'b0;
            repeat (st) begin
                tick();
                if (chg_coin !== held || chg_valid !== 1'b1) stable_ok = 1'b0;
            end
            if (chg_coin) got_str = {got_str, "10 "};
            else          got_str = {got_str, "5 "};
            chg_ready = 1'b1; tick(); chg_ready = 1'b0;
            guard++;
        end
        if (guard >= 40) got_str = {got_str, "TIMEOUT"};
    endtask

    task automatic test_reset();
        rst = 1'b1; coin = 2'b00; sel_valid = 1'b0; sel_id = 2'b00; cancel = 1'b0;
        restock = 1'b0; vend_ready = 1'b0; chg_ready = 1'b0;
        repeat (2) tick();
        n_cmp++; if (credit !== 8'd0) begin n_bad++; $display("FAIL reset_credit: got %0d want 0", credit); end
        n_cmp++; if ({vend_valid, chg_valid, coin_reject, sel_err} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_outputs: got %b want 0000", {vend_valid, chg_valid, coin_reject, sel_err}); end
        n_cmp++; if (sold_out !== 4'b0000) begin n_bad++; $display("FAIL reset_sold_out: got %b want 0000", sold_out); end
        @(negedge clk); rst = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) stock_m[i] = 3;
    endtask

    task automatic test_exact_price();
        put_coin(2'b10); put_coin(2'b01);
        n_cmp++; if (credit !== 8'd15) begin n_bad++; $display("FAIL exact_credit: got %0d want 15", credit); end
        pick(2'd0);
        n_cmp++; if (vend_valid !== 1'b1 || vend_id !== 2'd0) begin
            n_bad++; $display("FAIL exact_vend: got valid=%b id=%0d want 1/0", vend_valid, vend_id); end
        n_cmp++; if (credit !== 8'd0) begin n_bad++; $display("FAIL exact_debit: got %0d want 0", credit); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (vend_valid !== 1'b1 || vend_id !== 2'd0) begin
                n_bad++; $display("FAIL exact_hold: got valid=%b id=%0d want 1/0", vend_valid, vend_id); end
        end
        do_vend(0);
        stock_m[0]--;
        n_cmp++; if (vend_valid !== 1'b0 || chg_valid !== 1'b0) begin
            n_bad++; $display("FAIL exact_done: got vend=%b chg=%b want 0/0", vend_valid, chg_valid); end
        pick(2'd1);
        n_cmp++; if (sel_err !== 1'b1) begin n_bad++; $display("FAIL exact_idle_sel: got %b want 1", sel_err); end
    endtask

    task automatic test_change();
        put_coin(2'b10); put_coin(2'b10); put_coin(2'b10);
        pick(2'd0);
        n_cmp++; if (credit !== 8'd15) begin n_bad++; $display("FAIL chg_debit: got %0d want 15", credit); end
        do_vend(0);
        stock_m[0]--;
        n_cmp++; if (chg_valid !== 1'b1 || chg_coin !== 1'b1) begin
            n_bad++; $display("FAIL chg_first: got valid=%b coin=%b want 1/1", chg_valid, chg_coin); end
        repeat (2) begin
            tick();
            n_cmp++; if (chg_coin !== 1'b1) begin n_bad++; $display("FAIL chg_stall10: got %b want 1", chg_coin); end
        end
        chg_ready = 1'b1; tick(); chg_ready = 1'b0;
        n_cmp++; if (credit !== 8'd5 || chg_coin !== 1'b0 || chg_valid !== 1'b1) begin
            n_bad++; $display("FAIL chg_second: got credit=%0d coin=%b valid=%b want 5/0/1", credit, chg_coin, chg_valid); end
        repeat (2) begin
            tick();
            n_cmp++; if (chg_coin !== 1'b0) begin n_bad++; $display("FAIL chg_stall5: got %b want 0", chg_coin); end
        end
        chg_ready = 1'b1; tick(); chg_ready = 1'b0;
        n_cmp++; if (credit !== 8'd0 || chg_valid !== 1'b0) begin
            n_bad++; $display("FAIL chg_end: got credit=%0d valid=%b want 0/0", credit, chg_valid); end
    endtask

    task automatic test_refused();
        put_coin(2'b10);
        pick(2'd1);
        n_cmp++; if (sel_err !== 1'b1 || credit !== 8'd10) begin
            n_bad++; $display("FAIL refuse_credit: got err=%b credit=%0d want 1/10", sel_err, credit); end
        tick();
        n_cmp++; if (sel_err !== 1'b0) begin n_bad++; $display("FAIL refuse_pulse: got %b want 0", sel_err); end
        pulse_cancel();
        collect_change(1);
        for (int k = 0; k < 3; k++) begin
            put_coin(2'b10); put_coin(2'b10); put_coin(2'b01);
            pick(2'd2);
            n_cmp++; if (vend_valid !== 1'b1 || vend_id !== 2'd2) begin
                n_bad++; $display("FAIL drain_vend: got valid=%b id=%0d want 1/2", vend_valid, vend_id); end
            do_vend(0);
            stock_m[2]--;
        end
        n_cmp++; if (sold_out !== 4'b0100) begin n_bad++; $display("FAIL drain_sold_out: got %b want 0100", sold_out); end
        put_coin(2'b10); put_coin(2'b10); put_coin(2'b01);
        pick(2'd2);
        n_cmp++; if (sel_err !== 1'b1 || vend_valid !== 1'b0 || credit !== 8'd25) begin
            n_bad++; $display("FAIL soldout_sel: got err=%b vend=%b credit=%0d want 1/0/25", sel_err, vend_valid, credit); end
        pulse_cancel();
        collect_change(2);
        n_cmp++; if (got_str != change_plan(25)) begin n_bad++; $display("FAIL soldout_refund: got '%s' want '%s'", got_str, change_plan(25)); end
        restock = 1'b1; tick(); restock = 1'b0;
        for (int i = 0; i < 4; i++) stock_m[i] = 3;
        n_cmp++; if (sold_out !== 4'b0000) begin n_bad++; $display("FAIL restock: got %b want 0000", sold_out); end
    endtask

    task automatic test_coin_reject();
        put_coin(2'b11);
        n_cmp++; if (coin_reject !== 1'b1 || credit !== 8'd0) begin
            n_bad++; $display("FAIL rej_invalid: got rej=%b credit=%0d want 1/0", coin_reject, credit); end
        tick();
        n_cmp++; if (coin_reject !== 1'b0) begin n_bad++; $display("FAIL rej_pulse: got %b want 0", coin_reject); end
        repeat (9) put_coin(2'b10);
        put_coin(2'b01);
        put_coin(2'b10);
        n_cmp++; if (coin_reject !== 1'b1 || credit !== 8'd95) begin
            n_bad++; $display("FAIL rej_overflow: got rej=%b credit=%0d want 1/95", coin_reject, credit); end
        put_coin(2'b01);
        n_cmp++; if (coin_reject !== 1'b0 || credit !== 8'd100) begin
            n_bad++; $display("FAIL rej_fill: got rej=%b credit=%0d want 0/100", coin_reject, credit); end
        pick(2'd0);
        put_coin(2'b10);
        n_cmp++; if (coin_reject !== 1'b1 || credit !== 8'd85 || vend_valid !== 1'b1) begin
            n_bad++; $display("FAIL rej_vend: got rej=%b credit=%0d vend=%b want 1/85/1", coin_reject, credit, vend_valid); end
        do_vend(1);
        stock_m[0]--;
        collect_change(1);
        n_cmp++; if (got_str != change_plan(85) || !stable_ok) begin
            n_bad++; $display("FAIL rej_change: got '%s' stable=%b want '%s' stable=1", got_str, stable_ok, change_plan(85)); end
    endtask

    task automatic test_cancel();
        put_coin(2'b10); put_coin(2'b10); put_coin(2'b01);
        pulse_cancel();
        collect_change(2);
        n_cmp++; if (got_str != "10 10 5 ") begin n_bad++; $display("FAIL cancel_refund: got '%s' want '10 10 5 '", got_str); end
        put_coin(2'b10); put_coin(2'b10);
        cancel = 1'b1; sel_valid = 1'b1; sel_id = 2'd0;
        tick();
        cancel = 1'b0; sel_valid = 1'b0;
        n_cmp++; if (vend_valid !== 1'b0 || sel_err !== 1'b0 || chg_valid !== 1'b1) begin
            n_bad++; $display("FAIL cancel_beats_sel: got vend=%b err=%b chg=%b want 0/0/1", vend_valid, sel_err, chg_valid); end
        collect_change(0);
        n_cmp++; if (got_str != "10 10 ") begin n_bad++; $display("FAIL cancel_sel_refund: got '%s' want '10 10 '", got_str); end
    endtask

    task automatic test_timeout();
        put_coin(2'b01);
        repeat (199) tick();
        n_cmp++; if (chg_valid !== 1'b0) begin n_bad++; $display("FAIL timeout_early: got %b want 0", chg_valid); end
        tick();
        n_cmp++; if (chg_valid !== 1'b1 || chg_coin !== 1'b0) begin
            n_bad++; $display("FAIL timeout_fire: got valid=%b coin=%b want 1/0", chg_valid, chg_coin); end
        collect_change(1);
        n_cmp++; if (got_str != "5 ") begin n_bad++; $display("FAIL timeout_refund: got '%s' want '5 '", got_str); end
    endtask

    task automatic test_reset_mid_vend();
        put_coin(2'b10);
        pick(2'd1);
        put_coin(2'b10);
        pick(2'd1);
        n_cmp++; if (vend_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_setup: got %b want 1", vend_valid); end
        #3 rst = 1'b1;
        #1;
        n_cmp++; if (vend_valid !== 1'b0 || credit !== 8'd0) begin
            n_bad++; $display("FAIL rstmid_async: got vend=%b credit=%0d want 0/0", vend_valid, credit); end
        #2 rst = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) stock_m[i] = 3;
        n_cmp++; if (sold_out !== 4'b0000 || chg_valid !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_after: got sold=%b chg=%b want 0000/0", sold_out, chg_valid); end
    endtask

    // Random sessions: coins, one selection, dispense and change vs the model
    task automatic test_random();
        int         cr, v, p, n;
        logic [1:0] c;
        logic       exp_rej;
        bit         ok;
        for (int t = 0; t < 40; t++) begin
            cr = 0;
            if ($urandom_range(0, 5) == 0) begin
                restock = 1'b1; tick(); restock = 1'b0;
                for (int i = 0; i < 4; i++) stock_m[i] = 3;
            end
            n = $urandom_range(1, 8);
            for (int k = 0; k < n; k++) begin
                c = 2'($urandom_range(1, 3));
                v = (c == 2'b01) ? 5 : (c == 2'b10) ? 10 : 0;
                put_coin(c);
                if (v != 0 && cr + v <= 100) begin exp_rej = 1'b0; cr += v; end
                else exp_rej = 1'b1;
                n_cmp++; if (coin_reject !== exp_rej || credit !== 8'(cr)) begin
                    n_bad++; $display("FAIL rnd_coin: got rej=%b credit=%0d want %b/%0d", coin_reject, credit, exp_rej, cr); end
            end
            p = $urandom_range(0, 3);
            pick(2'(p));
            if (cr == 0) begin
                n_cmp++; if (sel_err !== 1'b1) begin n_bad++; $display("FAIL rnd_idle_sel: got %b want 1", sel_err); end
                continue;
            end
            ok = (stock_m[p] > 0) && (cr >= price_m[p]);
            if (ok) begin
                cr -= price_m[p];
                n_cmp++; if (vend_valid !== 1'b1 || vend_id !== 2'(p) || credit !== 8'(cr)) begin
                    n_bad++; $display("FAIL rnd_vend: got vend=%b id=%0d credit=%0d want 1/%0d/%0d", vend_valid, vend_id, credit, p, cr); end
                do_vend($urandom_range(0, 3));
                stock_m[p]--;
            end else begin
                n_cmp++; if (sel_err !== 1'b1 || vend_valid !== 1'b0 || credit !== 8'(cr)) begin
                    n_bad++; $display("FAIL rnd_refuse: got err=%b vend=%b credit=%0d want 1/0/%0d", sel_err, vend_valid, credit, cr); end
                pulse_cancel();
            end
            collect_change(3);
            n_cmp++; if (got_str != change_plan(cr) || !stable_ok) begin
                n_bad++; $display("FAIL rnd_change: got '%s' stable=%b want '%s' stable=1", got_str, stable_ok, change_plan(cr)); end
            n_cmp++; if (sold_out !== sold_model()) begin
                n_bad++; $display("FAIL rnd_sold_out: got %b want %b", sold_out, sold_model()); end
        end
    endtask

    initial begin
        test_reset();
        test_exact_price();
        test_change();
        test_refused();
        test_coin_reject();
        test_cancel();
        test_timeout();
        test_reset_mid_vend();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
